// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: state enum, opcodes and datapath select encodings shared by the control unit.
// Rev 1.0
`default_nettype none

package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic branch_f3_ok(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return (f3 != 3'b010) && (f3 != 3'b011);
`else
    return (f3 == 3'b000) || (f3 == 3'b001);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction/flag/memory inputs and datapath controls of the control unit.
// Rev 1.0
`default_nettype none

interface multicycle_control_unit_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       sign;
  logic       overflow;
  logic       carry;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       mem_req;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal_instr;
  logic       bus_err;

  modport master (
    input  op, funct3, funct7b5, zero, sign, overflow, carry, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write, mem_req,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           illegal_instr, bus_err
  );

  modport slave (
    output op, funct3, funct7b5, zero, sign, overflow, carry, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write, mem_req,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           illegal_instr, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit_alu_dec.sv
// alu_decoder_mc: maps ALUOp/funct3/funct7b5/op[5] to alu_control; flags shift encodings as unsupported.
// Rev 1.0
`default_nettype none

module alu_decoder_mc
  import multicycle_control_unit_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o,
  output logic       unsupported_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    unsupported_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          3'b100:  alu_control_o = ALU_XOR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: unsupported_o = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the multicycle RV32I datapath with memory wait timeout.
// Rev 1.0 -- define BRANCH_EXT_EN for blt/bge/bltu/bgeu in addition to beq/bne.
`default_nettype none

module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_control_unit_if.master     bus
);

  localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic       pc_write, adr_src, ir_write, mem_write, reg_write, mem_req;
  logic       illegal_instr, bus_err;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, aluop;
  logic [2:0] alu_control;
  logic       alu_unsupported;
  logic       taken;
  logic       in_wait_state;
  logic       timeout;

  alu_decoder_mc u_alu_dec (
    .aluop_i       (aluop),
    .funct3_i      (bus.funct3),
    .funct7b5_i    (bus.funct7b5),
    .op5_i         (bus.op[5]),
    .alu_control_o (alu_control),
    .unsupported_o (alu_unsupported)
  );

  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = ~bus.zero;
`ifdef BRANCH_EXT_EN
      3'b100:  taken = bus.sign ^ bus.overflow;
      3'b101:  taken = ~(bus.sign ^ bus.overflow);
      3'b110:  taken = ~bus.carry;
      3'b111:  taken = bus.carry;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef BRANCH_EXT_EN
  logic unused_flags;
  assign unused_flags = ^{bus.sign, bus.overflow, bus.carry};
`endif

  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // A ready response in the timeout cycle still completes the access.
  assign timeout = in_wait_state && !bus.mem_ready && (wait_q == C_TIMEOUT);

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_req       = 1'b0;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    imm_src       = IMM_I;
    aluop         = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        // jal reuses the decode-cycle target add, so it needs the J immediate here.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (bus.op == OP_JAL) ? IMM_J : IMM_B;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = branch_f3_ok(bus.funct3) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD, S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = (state_q == S_MEMWRITE);
        if (bus.mem_ready) begin
          state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_DATA;
        state_d    = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        aluop     = ALUOP_FUNCT;
        state_d   = alu_unsupported ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        aluop     = ALUOP_SUB;
        pc_write  = taken;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    if ((state_d != state_q) || timeout || !in_wait_state) begin
      wait_d = 8'd0;
    end else if (!bus.mem_ready) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are forced low while reset is held so no enable leaks through.
  assign bus.pc_write      = pc_write & ~reset;
  assign bus.adr_src       = adr_src & ~reset;
  assign bus.ir_write      = ir_write & ~reset;
  assign bus.mem_write     = mem_write & ~reset;
  assign bus.reg_write     = reg_write & ~reset;
  assign bus.mem_req       = mem_req & ~reset;
  assign bus.illegal_instr = illegal_instr & ~reset;
  assign bus.bus_err       = bus_err & ~reset;
  assign bus.result_src    = reset ? 2'b00 : result_src;
  assign bus.alu_src_a     = reset ? 2'b00 : alu_src_a;
  assign bus.alu_src_b     = reset ? 2'b00 : alu_src_b;
  assign bus.imm_src       = reset ? 2'b00 : imm_src;
  assign bus.alu_control   = reset ? 3'b000 : alu_control;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed scenarios for the multicycle control unit.
// Rev 1.0
`default_nettype none

module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input state_e exp);
    checks++;
    if (dut.state_q !== exp) begin
      errors++;
      $display("FAIL %s: state got %0d expected %0d", name, dut.state_q, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.sign = 1'b0; bus.overflow = 1'b0; bus.carry = 1'b0;
    bus.mem_ready = 1'b0;
    cyc(); cyc();
    #1;
    chk_state("reset_state", S_FETCH);
    checks++;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.adr_src !== 1'b0 || bus.ir_write !== 1'b0 || bus.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_fetch: mem_req=%b adr_src=%b ir_write=%b reg_write=%b expected 1 0 0 0",
               bus.mem_req, bus.adr_src, bus.ir_write, bus.reg_write);
    end
    cyc();
  endtask

  task automatic test_rtype_add();
    bus.op = OP_RTYPE; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin
      errors++; $display("FAIL add_fetch: ir_write=%b pc_write=%b expected 1 1", bus.ir_write, bus.pc_write);
    end
    cyc(); chk_state("add_c2", S_DECODE);
    checks++;
    if (bus.reg_write !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL add_decode: reg_write=%b mem_req=%b expected 0 0", bus.reg_write, bus.mem_req);
    end
    cyc(); chk_state("add_c3", S_EXECR);
    checks++;
    if (bus.alu_control !== 3'b000 || bus.alu_src_a !== 2'b10 || bus.reg_write !== 1'b0) begin
      errors++; $display("FAIL add_exec: alu_control=%b alu_src_a=%b reg_write=%b expected 000 10 0",
                         bus.alu_control, bus.alu_src_a, bus.reg_write);
    end
    cyc(); chk_state("add_c4", S_ALUWB);
    checks++;
    if (bus.reg_write !== 1'b1 || bus.result_src !== 2'b00) begin
      errors++; $display("FAIL add_wb: reg_write=%b result_src=%b expected 1 00", bus.reg_write, bus.result_src);
    end
    cyc(); chk_state("add_c5", S_FETCH);
    checks++;
    if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL add_c5_reg_write: got %b expected 0", bus.reg_write); end
  endtask

  task automatic test_sub_wait();
    bus.op = OP_RTYPE; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.ir_write !== 1'b0 || dut.state_q !== S_FETCH) begin
        errors++; $display("FAIL sub_stall%0d: ir_write=%b state=%0d expected 0 FETCH", i, bus.ir_write, dut.state_q);
      end
      cyc();
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.ir_write !== 1'b1) begin errors++; $display("FAIL sub_ir_write: got %b expected 1", bus.ir_write); end
    cyc(); cyc(); chk_state("sub_exec", S_EXECR);
    checks++;
    if (bus.alu_control !== 3'b001) begin errors++; $display("FAIL sub_alu_control: got %b expected 001", bus.alu_control); end
    cyc(); cyc(); chk_state("sub_done", S_FETCH);
  endtask

  task automatic test_itype();
    // xori with instr[30]=1: must not turn into sub and decodes to xor
    bus.op = OP_ITYPE; bus.funct3 = 3'b100; bus.funct7b5 = 1'b1; bus.mem_ready = 1'b1;
    cyc(); cyc(); chk_state("xori_exec", S_EXECI);
    checks++;
    if (bus.alu_control !== 3'b100 || bus.alu_src_b !== 2'b01) begin
      errors++; $display("FAIL xori: alu_control=%b alu_src_b=%b expected 100 01", bus.alu_control, bus.alu_src_b);
    end
    cyc(); cyc();
    bus.funct3 = 3'b000;
    cyc(); cyc();
    checks++;
    if (bus.alu_control !== 3'b000) begin errors++; $display("FAIL addi_f7: got %b expected 000", bus.alu_control); end
    cyc(); cyc();
    // slli is unsupported
    bus.funct3 = 3'b001; bus.funct7b5 = 1'b0;
    cyc(); cyc(); cyc(); chk_state("slli_trap", S_TRAP);
    checks++;
    if (bus.illegal_instr !== 1'b1) begin errors++; $display("FAIL slli_illegal: got %b expected 1", bus.illegal_instr); end
    cyc(); chk_state("slli_done", S_FETCH);
  endtask

  task automatic test_load_ok();
    bus.op = OP_LOAD; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.mem_ready = 1'b1;
    cyc(); cyc(); chk_state("lw_memadr", S_MEMADR);
    checks++;
    if (bus.imm_src !== 2'b00 || bus.alu_src_a !== 2'b10 || bus.alu_src_b !== 2'b01) begin
      errors++; $display("FAIL lw_memadr_ctl: imm_src=%b src_a=%b src_b=%b expected 00 10 01",
                         bus.imm_src, bus.alu_src_a, bus.alu_src_b);
    end
    cyc(); chk_state("lw_memread", S_MEMREAD);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.adr_src !== 1'b1 || bus.mem_write !== 1'b0) begin
      errors++; $display("FAIL lw_memread_ctl: mem_req=%b adr_src=%b mem_write=%b expected 1 1 0",
                         bus.mem_req, bus.adr_src, bus.mem_write);
    end
    cyc(); chk_state("lw_memwb", S_MEMWB);
    checks++;
    if (bus.reg_write !== 1'b1 || bus.result_src !== 2'b01) begin
      errors++; $display("FAIL lw_wb: reg_write=%b result_src=%b expected 1 01", bus.reg_write, bus.result_src);
    end
    cyc(); chk_state("lw_done", S_FETCH);
  endtask

  task automatic test_lw_timeout();
    int pulses = 0;
    int regw   = 0;
    bus.op = OP_LOAD; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
    cyc(); cyc();
    bus.mem_ready = 1'b0;
    cyc(); chk_state("to_memread", S_MEMREAD);
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.bus_err === 1'b1) pulses++;
      if (bus.reg_write === 1'b1) regw++;
      checks++;
      if (bus.bus_err !== (i == 15)) begin
        errors++; $display("FAIL to_bus_err_c%0d: got %b expected %b", i, bus.bus_err, (i == 15));
      end
      cyc();
    end
    chk_state("to_fetch", S_FETCH);
    checks++;
    if (pulses != 1 || regw != 0 || bus.bus_err !== 1'b0) begin
      errors++; $display("FAIL to_summary: pulses=%0d reg_write_cycles=%0d bus_err=%b expected 1 0 0",
                         pulses, regw, bus.bus_err);
    end
  endtask

  task automatic test_branch();
    bus.op = OP_BRANCH; bus.funct3 = 3'b000; bus.mem_ready = 1'b1;
    cyc(); cyc(); chk_state("beq_state", S_BRANCH);
    bus.zero = 1'b1; #1;
    checks++;
    if (bus.pc_write !== 1'b1 || bus.alu_control !== 3'b001) begin
      errors++; $display("FAIL beq_taken: pc_write=%b alu_control=%b expected 1 001", bus.pc_write, bus.alu_control);
    end
    bus.zero = 1'b0; #1;
    checks++;
    if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %b expected 0", bus.pc_write); end
    cyc(); chk_state("beq_done", S_FETCH);
    bus.funct3 = 3'b001;
    cyc(); cyc();
    checks++;
    if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL bne_taken: got %b expected 1", bus.pc_write); end
    cyc();
    bus.funct3 = 3'b100;
    cyc(); cyc();
`ifdef BRANCH_EXT_EN
    chk_state("blt_state", S_BRANCH);
    bus.sign = 1'b1; bus.overflow = 1'b0; #1;
    checks++;
    if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL blt_taken: got %b expected 1", bus.pc_write); end
    bus.overflow = 1'b1; #1;
    checks++;
    if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL blt_not_taken: got %b expected 0", bus.pc_write); end
    bus.carry = 1'b0; bus.funct3 = 3'b110; #1;
    checks++;
    if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL bltu_taken: got %b expected 1", bus.pc_write); end
`else
    chk_state("blt_trap", S_TRAP);
    checks++;
    if (bus.illegal_instr !== 1'b1) begin errors++; $display("FAIL blt_illegal: got %b expected 1", bus.illegal_instr); end
`endif
    cyc(); chk_state("blt_done", S_FETCH);
    bus.sign = 1'b0; bus.overflow = 1'b0; bus.carry = 1'b0;
  endtask

  task automatic test_jal();
    bus.op = OP_JAL; bus.mem_ready = 1'b1;
    cyc();
    checks++;
    if (bus.imm_src !== 2'b11) begin errors++; $display("FAIL jal_decode_imm: got %b expected 11", bus.imm_src); end
    cyc(); chk_state("jal_state", S_JAL);
    checks++;
    if (bus.pc_write !== 1'b1 || bus.alu_src_a !== 2'b01 || bus.alu_src_b !== 2'b10) begin
      errors++; $display("FAIL jal_ctl: pc_write=%b src_a=%b src_b=%b expected 1 01 10",
                         bus.pc_write, bus.alu_src_a, bus.alu_src_b);
    end
    cyc(); chk_state("jal_wb", S_ALUWB);
    cyc(); chk_state("jal_done", S_FETCH);
  endtask

  task automatic test_illegal();
    bus.op = 7'b1111111; bus.mem_ready = 1'b1;
    cyc(); chk_state("ill_c2", S_DECODE);
    checks++;
    if (bus.illegal_instr !== 1'b0) begin errors++; $display("FAIL ill_c2_pulse: got %b expected 0", bus.illegal_instr); end
    cyc(); chk_state("ill_c3", S_TRAP);
    checks++;
    if (bus.illegal_instr !== 1'b1) begin errors++; $display("FAIL ill_c3_pulse: got %b expected 1", bus.illegal_instr); end
    cyc(); chk_state("ill_c4", S_FETCH);
    checks++;
    if (bus.illegal_instr !== 1'b0) begin errors++; $display("FAIL ill_c4_pulse: got %b expected 0", bus.illegal_instr); end
  endtask

  task automatic test_sw_reset();
    bus.op = OP_STORE; bus.mem_ready = 1'b1;
    cyc(); cyc();
    checks++;
    if (bus.imm_src !== 2'b01) begin errors++; $display("FAIL sw_imm_src: got %b expected 01", bus.imm_src); end
    bus.mem_ready = 1'b0;
    cyc(); chk_state("sw_memwrite", S_MEMWRITE);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL sw_write_ctl: mem_write=%b mem_req=%b expected 1 1", bus.mem_write, bus.mem_req);
    end
    reset = 1'b1;
    cyc(); chk_state("sw_reset_state", S_FETCH);
    checks++;
    if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL sw_reset_mem_write: got %b expected 0", bus.mem_write); end
    reset = 1'b0; #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL sw_after_reset: mem_write=%b mem_req=%b expected 0 1", bus.mem_write, bus.mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_sub_wait();
    test_itype();
    test_load_ok();
    test_lw_timeout();
    test_branch();
    test_jal();
    test_illegal();
    test_sw_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
